lsu_port_arb: RTL and testbench
===============================

# lsu_port_arb

Two-master arbiter and sequencer in front of the load/store unit. It lets the core pipeline (master 0) and a debug/DMA port (master 1) share the single LSU address/store/load port. Accesses are granted round-robin, registered onto the LSU port, and read data is returned with a one-cycle `rvalid` pulse to the owning master. Stores to the read-only switch region are blocked.

## Interface
- `ADDR_W`, 11, LSU byte/word address width; bits [ADDR_W-1:ADDR_W-3] select the region.
- `DATA_W`, 32, data width.
- `RD_LAT`, 1, cycles from the LSU address being registered to `lsu_ld_data_i` being valid (0..3).
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset: one clock; asynchronous, active-high.
- `mN_req_i`  in  1  master N (N=0,1) request; held until granted.
- `mN_we_i`  in  1  1 = store, 0 = load.
- `mN_addr_i`  in  ADDR_W  access address.
- `mN_wdata_i`  in  DATA_W  store data.
- `mN_gnt_o`  out  1  combinational grant; request fields are captured on this edge.
- `mN_rvalid_o`  out  1  one-cycle pulse; `mN_rdata_o` is valid.
- `mN_rdata_o`  out  DATA_W  load data, held until the next load completes for that master.
- `mN_wdrop_o`  out  1  one-cycle pulse: the granted store targeted the read-only region and was dropped.
- `lsu_addr_o`  out  ADDR_W  registered LSU address.
- `lsu_st_data_o`  out  DATA_W  registered store data.
- `lsu_st_en_o`  out  1  store enable, high for exactly one cycle per accepted store.
- `lsu_ld_data_i`  in  DATA_W  LSU load data.
- `busy_o`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, ACCESS, RWAIT.
- IDLE:
  - If any request is present, grant one master.
  - If both request, grant the master that was not served last (`last` register).
  - Latch `we`, `addr`, `wdata` and the owner into the LSU output registers. Go to ACCESS.
- ACCESS, store:
  - `lsu_st_en_o`=1 unless `addr[ADDR_W-1:ADDR_W-3]`==3'b101 (switch input region).
  - If dropped: `lsu_st_en_o`=0 and `mN_wdrop_o`=1 for the owner.
  - Return to IDLE.
- ACCESS, load:
  - If RD_LAT=0, sample `lsu_ld_data_i` this cycle.
  - Otherwise go to RWAIT with counter=RD_LAT-1.
- RWAIT:
  - Decrement the counter each cycle.
  - When it reaches 0, sample `lsu_ld_data_i` that cycle.
- After the load sample: owner's `rdata` register is loaded, `mN_rvalid_o` pulses in the following cycle, and the FSM is in IDLE during that cycle.
- `lsu_addr_o` and `lsu_st_data_o` hold their values from ACCESS until the next grant; they never change during RWAIT.
- `lsu_st_en_o` is 0 in all states except ACCESS with an accepted store.
- At most one grant outstanding; no grants outside IDLE.
- `last` updates at every grant. After reset, `last`=1, so master 0 wins the first tie.
- A master may drop `req` before being granted with no effect. Fields are ignored when not granted.

## Timing
- Grant in cycle T, combinational with `req` in IDLE.
- Store: `lsu_st_en_o` high in T+1; next grant possible in T+2. Back-to-back stores give 1 access per 2 cycles.
- Load: address on the LSU from T+1; data sampled at the end of T+1+RD_LAT; `rvalid` high in T+2+RD_LAT; a new grant is possible in that same cycle.
- Reset, asynchronous at any time including mid-access:
  - FSM=IDLE, counter=0, `last`=1.
  - Outputs: all `gnt`/`rvalid`/`wdrop`/`lsu_st_en_o`/`busy_o`=0; `lsu_addr_o`, `lsu_st_data_o`, `mN_rdata_o`=0.
  - An in-flight load produces no `rvalid`; an in-flight store never asserts `st_en`.
- Simultaneous `rvalid` for master A and a new grant to master B in the same cycle is legal and required.

## Test plan
- Single store, m0 addr 0x004, data 0xDEADBEEF, RD_LAT=1 -> `m0_gnt_o` at T; `lsu_st_en_o`=1, `lsu_addr_o`=0x004, `lsu_st_data_o`=0xDEADBEEF in T+1 only; `busy_o` low in T+2.
- Load m1 addr 0x010, LSU returns 0x12345678 with RD_LAT=2 -> `m1_rvalid_o` pulses in T+4 with `m1_rdata_o`=0x12345678; `m0_rvalid_o` stays 0.
- Both masters request continuously (stores) -> grants alternate m0,m1,m0,m1 every 2 cycles, with m0 first after reset; no starvation over 100 grants.
- Store by m0 to 0x500 -> `lsu_st_en_o` stays 0; `m0_wdrop_o` pulses in T+1. Load from 0x500 completes normally.
- Assert `rst_i` in the RWAIT cycle of an m0 load -> all outputs 0 immediately; no `m0_rvalid_o` after release; the next request is granted in the first cycle after release.
- RD_LAT=0, load then immediate m1 store request -> `m0_rvalid_o` and `m1_gnt_o` both high in T+2; `lsu_st_en_o` in T+3.

Source files
------------

// File: rtl/lsu_port_arb_if.sv
// Bundle between the two requesting masters, the LSU port and lsu_port_arb.
// slave = arbiter side, master = requester/LSU side.
interface lsu_port_arb_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m0_gnt_o;
  logic              m0_rvalid_o;
  logic [DATA_W-1:0] m0_rdata_o;
  logic              m0_wdrop_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;
  logic [DATA_W-1:0] m1_rdata_o;
  logic              m1_wdrop_o;

  logic [ADDR_W-1:0] lsu_addr_o;
  logic [DATA_W-1:0] lsu_st_data_o;
  logic              lsu_st_en_o;
  logic [DATA_W-1:0] lsu_ld_data_i;
  logic              busy_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  lsu_ld_data_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_wdrop_o,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_wdrop_o,
    output lsu_addr_o, lsu_st_data_o, lsu_st_en_o, busy_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output lsu_ld_data_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_wdrop_o,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_wdrop_o,
    input  lsu_addr_o, lsu_st_data_o, lsu_st_en_o, busy_o
  );
endinterface

// File: rtl/lsu_port_arb.sv
// Round-robin two-master arbiter in front of the single LSU port, with
// per-master load return and read-only-region store blocking.

// Per-master return slot: load data register, rvalid and wdrop pulses.
module lsu_port_arb_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_smp,
  input  logic              drop,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rvalid,
  output logic              wdrop,
  output logic [DATA_W-1:0] rdata
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid <= 1'b0;
      wdrop  <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= ld_smp;
      wdrop  <= drop;
      if (ld_smp) rdata <= ld_data;
    end
  end
endmodule

module lsu_port_arb #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic           clk_i,
  input logic           rst_i,
  lsu_port_arb_if.slave bus
);
  localparam int         NUM_M     = 2;
  localparam logic [2:0] RO_REGION = 3'b101;
  localparam logic [1:0] CNT_INIT  = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  state_t            state;
  logic [1:0]        cnt;
  logic              last_r;
  logic              we_r;
  logic [NUM_M-1:0]  owner_oh;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_st_data;
  logic              lsu_st_en;

  mreq_t [NUM_M-1:0] mreq;
  logic  [NUM_M-1:0] req, gnt;
  logic              win;
  mreq_t             sel;
  logic              sel_ro;
  logic              ld_smp;

  logic [NUM_M-1:0]             ld_smp_m, drop_m, rvalid_m, wdrop_m;
  logic [NUM_M-1:0][DATA_W-1:0] rdata_m;

  assign mreq[0] = {bus.m0_we_i, bus.m0_addr_i, bus.m0_wdata_i};
  assign mreq[1] = {bus.m1_we_i, bus.m1_addr_i, bus.m1_wdata_i};
  assign req     = {bus.m1_req_i, bus.m0_req_i};

  // last_r=1 means master 1 was served last, so master 0 wins a tie.
  always_comb begin
    gnt = '0;
    if (!rst_i && state == IDLE) begin
      if (req[0] && (!req[1] || last_r)) gnt[0] = 1'b1;
      else if (req[1])                   gnt[1] = 1'b1;
    end
  end

  assign win    = gnt[1];
  assign sel    = mreq[win];
  assign sel_ro = (sel.addr[ADDR_W-1 -: 3] == RO_REGION);
  assign drop_m = gnt & {NUM_M{sel.we & sel_ro}};

  // Load data is taken on the edge closing the last latency cycle.
  assign ld_smp   = (state == RWAIT && cnt == 2'd0) ||
                    (RD_LAT == 0 && state == ACCESS && !we_r);
  assign ld_smp_m = owner_oh & {NUM_M{ld_smp}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      last_r      <= 1'b1;
      we_r        <= 1'b0;
      owner_oh    <= '0;
      lsu_addr    <= '0;
      lsu_st_data <= '0;
      lsu_st_en   <= 1'b0;
    end else begin
      lsu_st_en <= 1'b0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner_oh    <= gnt;
            last_r      <= win;
            we_r        <= sel.we;
            lsu_addr    <= sel.addr;
            lsu_st_data <= sel.wdata;
            lsu_st_en   <= sel.we && !sel_ro;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_r || RD_LAT == 0) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_INIT;
            state <= RWAIT;
          end
        end
        RWAIT: begin
          if (cnt == 2'd0) state <= IDLE;
          else             cnt   <= cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  lsu_port_arb_slot #(.DATA_W(DATA_W)) u_slot [NUM_M-1:0] (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .ld_smp  (ld_smp_m),
    .drop    (drop_m),
    .ld_data (bus.lsu_ld_data_i),
    .rvalid  (rvalid_m),
    .wdrop   (wdrop_m),
    .rdata   (rdata_m)
  );

  assign bus.m0_gnt_o      = gnt[0];
  assign bus.m1_gnt_o      = gnt[1];
  assign bus.m0_rvalid_o   = rvalid_m[0];
  assign bus.m1_rvalid_o   = rvalid_m[1];
  assign bus.m0_rdata_o    = rdata_m[0];
  assign bus.m1_rdata_o    = rdata_m[1];
  assign bus.m0_wdrop_o    = wdrop_m[0];
  assign bus.m1_wdrop_o    = wdrop_m[1];
  assign bus.lsu_addr_o    = lsu_addr;
  assign bus.lsu_st_data_o = lsu_st_data;
  assign bus.lsu_st_en_o   = lsu_st_en;
  assign bus.busy_o        = (state != IDLE);
endmodule

// File: tb/tb_lsu_port_arb.sv
// Three lsu_port_arb instances (RD_LAT 0,1,2) on shared stimulus, each checked
// every cycle against a transaction-schedule model, plus directed sequences.
module tb_lsu_port_arb;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int OW = 8 + AW + 3 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, ld_data = '0;

  always #5 clk = ~clk;

  logic [1:0]    o_gnt [3];
  logic [1:0]    o_rv  [3];
  logic [1:0]    o_wd  [3];
  logic          o_st  [3];
  logic          o_busy[3];
  logic [AW-1:0] o_addr[3];
  logic [DW-1:0] o_std [3];
  logic [DW-1:0] o_rd0 [3];
  logic [DW-1:0] o_rd1 [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lsu_port_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    lsu_port_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(g)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
    );
    assign bus.m0_req_i      = req0;
    assign bus.m0_we_i       = we0;
    assign bus.m0_addr_i     = addr0;
    assign bus.m0_wdata_i    = wdata0;
    assign bus.m1_req_i      = req1;
    assign bus.m1_we_i       = we1;
    assign bus.m1_addr_i     = addr1;
    assign bus.m1_wdata_i    = wdata1;
    assign bus.lsu_ld_data_i = ld_data;
    assign o_gnt[g]  = {bus.m1_gnt_o, bus.m0_gnt_o};
    assign o_rv[g]   = {bus.m1_rvalid_o, bus.m0_rvalid_o};
    assign o_wd[g]   = {bus.m1_wdrop_o, bus.m0_wdrop_o};
    assign o_st[g]   = bus.lsu_st_en_o;
    assign o_busy[g] = bus.busy_o;
    assign o_addr[g] = bus.lsu_addr_o;
    assign o_std[g]  = bus.lsu_st_data_o;
    assign o_rd0[g]  = bus.m0_rdata_o;
    assign o_rd1[g]  = bus.m1_rdata_o;
  end

  int n_chk = 0, n_pass = 0, cyc = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
  endtask

  function automatic logic [OW-1:0] act(int k);
    return {o_gnt[k], o_rv[k], o_wd[k], o_st[k], o_busy[k], o_addr[k], o_std[k], o_rd1[k], o_rd0[k]};
  endfunction

  // Schedule model: a grant at cycle t books the port until next-free cycle
  // nf; every visible effect is a cycle number relative to that grant.
  int            nf[3], gt[3], st_at[3], smp_at[3], rv_at[3], wd_at[3], ap_at[3];
  logic          lastm[3];
  logic [1:0]    own[3];
  logic [AW-1:0] ma[3], pa[3];
  logic [DW-1:0] ms[3], ps[3], pld[3], mr0[3], mr1[3];

  task automatic model_reset(int k);
    nf[k] = cyc + 1; gt[k] = cyc; lastm[k] = 1'b1; own[k] = 2'b00;
    st_at[k] = -1; smp_at[k] = -1; rv_at[k] = -1; wd_at[k] = -1; ap_at[k] = -1;
    ma[k] = '0; pa[k] = '0; ms[k] = '0; ps[k] = '0; pld[k] = '0; mr0[k] = '0; mr1[k] = '0;
  endtask

  task automatic tick();
    logic [1:0] eg, erv, ewd;
    logic       est, eb, wev;
    logic [OW-1:0] ev;
    #1;
    for (int k = 0; k < 3; k++) begin
      eg = 2'b00; erv = 2'b00; ewd = 2'b00; est = 1'b0; eb = 1'b0;
      if (rst) begin
        model_reset(k);
      end else begin
        if (cyc == ap_at[k]) begin ma[k] = pa[k]; ms[k] = ps[k]; end
        if (cyc == rv_at[k]) begin
          if (own[k][0]) mr0[k] = pld[k];
          else           mr1[k] = pld[k];
        end
        if (cyc >= nf[k]) begin
          if (req0 && req1) eg = lastm[k] ? 2'b01 : 2'b10;
          else              eg = {req1, req0};
        end
        eb  = (cyc > gt[k]) && (cyc < nf[k]);
        est = (cyc == st_at[k]);
        ewd = (cyc == wd_at[k]) ? own[k] : 2'b00;
        erv = (cyc == rv_at[k]) ? own[k] : 2'b00;
      end
      ev = {eg, erv, ewd, est, eb, ma[k], ms[k], mr1[k], mr0[k]};
      check($sformatf("model_lat%0d", k), 128'(act(k)), 128'(ev));
      if (!rst) begin
        if (cyc == smp_at[k]) pld[k] = ld_data;
        if (eg != 2'b00) begin
          own[k] = eg; lastm[k] = eg[1]; gt[k] = cyc; ap_at[k] = cyc + 1;
          pa[k]  = eg[1] ? addr1 : addr0;
          ps[k]  = eg[1] ? wdata1 : wdata0;
          wev    = eg[1] ? we1 : we0;
          if (wev) begin
            if (pa[k][AW-1 -: 3] == 3'b101) wd_at[k] = cyc + 1;
            else                            st_at[k] = cyc + 1;
            nf[k] = cyc + 2;
          end else begin
            smp_at[k] = cyc + 1 + k;
            rv_at[k]  = cyc + 2 + k;
            nf[k]     = cyc + 2 + k;
          end
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic quiet(int n);
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [1:0]    req;
    logic [AW-1:0] a0, a1;
    logic [1:0]    gnt;
    logic          st_en;
    logic [1:0]    wdrop;
    logic [AW-1:0] addr;
  } vec_t;
  vec_t vt[9];

  initial begin
    logic [DW-1:0] exp_std;
    logic [1:0]    rr_exp;
    int            grants;

    vt[0] = '{2'b01, 11'h004, 11'h000, 2'b01, 1'b1, 2'b00, 11'h004};
    vt[1] = '{2'b11, 11'h500, 11'h010, 2'b10, 1'b1, 2'b00, 11'h010};
    vt[2] = '{2'b11, 11'h500, 11'h020, 2'b01, 1'b0, 2'b01, 11'h500};
    vt[3] = '{2'b10, 11'h000, 11'h5FF, 2'b10, 1'b0, 2'b10, 11'h5FF};
    vt[4] = '{2'b11, 11'h4FF, 11'h100, 2'b01, 1'b1, 2'b00, 11'h4FF};
    vt[5] = '{2'b11, 11'h200, 11'h600, 2'b10, 1'b1, 2'b00, 11'h600};
    vt[6] = '{2'b10, 11'h000, 11'h7FF, 2'b10, 1'b1, 2'b00, 11'h7FF};
    vt[7] = '{2'b11, 11'h000, 11'h300, 2'b01, 1'b1, 2'b00, 11'h000};
    vt[8] = '{2'b00, 11'h123, 11'h456, 2'b00, 1'b0, 2'b00, 11'h000};

    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("reset_outs", 128'(act(k)), 128'(0));
    tick(); tick();
    rst = 1'b0;

    // Store vectors from reset: arbitration, region blocking, register capture.
    exp_std = '0;
    for (int i = 0; i < 9; i++) begin
      req0 = vt[i].req[0]; req1 = vt[i].req[1]; we0 = 1'b1; we1 = 1'b1;
      addr0 = vt[i].a0; addr1 = vt[i].a1;
      wdata0 = 32'hA000_0000 + i; wdata1 = 32'hB000_0000 + i;
      if (vt[i].gnt == 2'b01) exp_std = wdata0;
      if (vt[i].gnt == 2'b10) exp_std = wdata1;
      #1;
      check("vec_gnt_busy", 128'({o_gnt[1], o_busy[1]}), 128'({vt[i].gnt, 1'b0}));
      tick();
      req0 = 1'b0; req1 = 1'b0;
      #1;
      check("vec_access", 128'({o_st[1], o_wd[1], o_addr[1], o_std[1]}),
            128'({vt[i].st_en, vt[i].wdrop, vt[i].addr, exp_std}));
      tick();
    end
    quiet(3);

    // m1 load, RD_LAT=2 instance: rvalid in T+4.
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'h010; ld_data = '0;
    #1;
    check("ld2_gnt", 128'(o_gnt[2]), 128'(2'b10));
    tick();
    req1 = 1'b0;
    tick(); tick();
    ld_data = 32'h1234_5678;
    tick();
    ld_data = '0;
    #1;
    check("ld2_rvalid", 128'({o_rv[2], o_rd1[2]}), 128'({2'b10, 32'h1234_5678}));
    tick();
    quiet(3);

    // Continuous store contention from reset: m0 first, then alternate.
    rst = 1'b1; tick(); rst = 1'b0;
    rr_exp = 2'b01; grants = 0;
    for (int i = 0; i < 200; i++) begin
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
      addr0 = 11'h004; addr1 = 11'h008;
      #1;
      check("rr_gnt", 128'(o_gnt[1]), 128'((i % 2 == 0) ? rr_exp : 2'b00));
      if (o_gnt[1] != 2'b00) grants++;
      if (i % 2 == 0) rr_exp = ~rr_exp;
      tick();
    end
    quiet(3);
    check("rr_count", 128'(grants), 128'(100));

    // Reset during RWAIT of an m0 load (RD_LAT=2 instance).
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h030;
    #1;
    check("rst_ld_gnt", 128'(o_gnt[2]), 128'(2'b01));
    tick();
    req0 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst_async", 128'(act(2)), 128'(0));
    tick();
    rst = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 11'h044;
    #1;
    check("gnt_after_rst", 128'(o_gnt[2]), 128'(2'b01));
    tick();
    req0 = 1'b0;
    #1;
    check("no_rvalid_after_rst", 128'(o_rv[2]), 128'(2'b00));
    tick();
    quiet(4);

    // RD_LAT=0: m0 rvalid and m1 grant together in T+2, store in T+3.
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h020;
    #1;
    check("l0_gnt0", 128'(o_gnt[0]), 128'(2'b01));
    tick();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 11'h0C0; wdata1 = 32'h55AA_55AA;
    ld_data = 32'hCAFE_F00D;
    #1;
    check("l0_nogrant_busy", 128'({o_gnt[0], o_busy[0]}), 128'({2'b00, 1'b1}));
    tick();
    ld_data = '0;
    #1;
    check("l0_rv_and_gnt", 128'({o_rv[0], o_gnt[0], o_rd0[0]}), 128'({2'b01, 2'b10, 32'hCAFE_F00D}));
    tick();
    req1 = 1'b0;
    #1;
    check("l0_store", 128'({o_st[0], o_addr[0], o_std[0]}), 128'({1'b1, 11'h0C0, 32'h55AA_55AA}));
    tick();
    quiet(4);

    // Random traffic, occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      req0 = ($urandom_range(9) < 6); req1 = ($urandom_range(9) < 6);
      we0 = $urandom_range(1) == 1; we1 = $urandom_range(1) == 1;
      addr0 = ($urandom_range(3) == 0) ? {3'b101, 8'($urandom)} : 11'($urandom);
      addr1 = ($urandom_range(3) == 0) ? {3'b101, 8'($urandom)} : 11'($urandom);
      wdata0 = $urandom; wdata1 = $urandom; ld_data = $urandom;
      rst = ($urandom_range(149) == 0);
      tick();
    end
    rst = 1'b0;
    quiet(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
